// File: rtl/tea_byte_stream_if.sv
// Byte-stream ports of tea_byte_stream: s_* carries bytes into the block, m_* carries them out.
interface tea_byte_stream_if;
  logic [7:0] s_data;
  logic       s_mode;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport slave (
    input  s_data, s_mode, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_mode, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );
endinterface

// File: rtl/tea_byte_stream.sv
// Byte-serial front/back end for the TEA core: 8 bytes in -> one core block -> 8 bytes out.
// Define TEA_STREAM_CBC_EN to build CBC chaining; otherwise the block is plain ECB.
module tea_byte_stream #(
  parameter int unsigned ROUNDS = 32
) (
  input  logic             clk,
  input  logic             reset,
  tea_byte_stream_if.slave strm,
  output logic [63:0]      core_in,
  output logic             core_mode,
  output logic             core_write,
  input  logic [63:0]      core_out,
  input  logic             core_out_ready,
  input  logic [63:0]      iv,
  input  logic             iv_load,
  output logic             busy
);
  typedef enum logic [1:0] {FILL, ISSUE, WAIT, DRAIN} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [63:0] blk_q;
  logic [63:0] out_q;
  logic [63:0] core_in_q;
  logic        core_mode_q;
  logic        core_write_q;
  logic        m_valid_q;

  logic [63:0] blk_d;
  logic [63:0] core_in_d;
  logic [63:0] result_d;
  logic        s_fire;
  logic        m_fire;
  logic        unused_rounds;

  // Round count lives entirely in the core; this block only waits on core_out_ready.
  assign unused_rounds = (ROUNDS == 0);

  assign s_fire = strm.s_valid && (state_q == FILL);
  assign m_fire = m_valid_q && strm.m_ready;
  assign blk_d  = {blk_q[55:0], strm.s_data};

`ifdef TEA_STREAM_CBC_EN
  logic [63:0] chain_q;
  logic [63:0] chain_d;

  // core_in_d is only consumed on byte 7, by which time core_mode_q holds this block's mode.
  always_comb begin
    core_in_d = blk_d ^ chain_q;
    result_d  = core_out;
    chain_d   = core_out;
    if (core_mode_q) begin
      core_in_d = blk_d;
      result_d  = core_out ^ chain_q;
      chain_d   = blk_q;
    end
  end
`else
  logic unused_cbc;

  assign core_in_d  = blk_d;
  assign result_d   = core_out;
  assign unused_cbc = ^{iv, iv_load};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      blk_q        <= '0;
      out_q        <= '0;
      core_in_q    <= '0;
      core_mode_q  <= 1'b0;
      core_write_q <= 1'b0;
      m_valid_q    <= 1'b0;
`ifdef TEA_STREAM_CBC_EN
      chain_q      <= '0;
`endif
    end else begin
      core_write_q <= 1'b0;
      case (state_q)
        FILL: begin
`ifdef TEA_STREAM_CBC_EN
          if (iv_load && (cnt_q == 3'd0)) chain_q <= iv;
`endif
          if (s_fire) begin
            blk_q <= blk_d;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd0) core_mode_q <= strm.s_mode;
            if (cnt_q == 3'd7) begin
              core_in_q    <= core_in_d;
              core_write_q <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (core_out_ready) begin
            out_q     <= result_d;
            m_valid_q <= 1'b1;
            state_q   <= DRAIN;
`ifdef TEA_STREAM_CBC_EN
            chain_q   <= chain_d;
`endif
          end
        end
        DRAIN: begin
          if (m_fire) begin
            out_q <= {out_q[55:0], 8'h00};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              m_valid_q <= 1'b0;
              state_q   <= FILL;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign strm.s_ready = (state_q == FILL);
  assign strm.m_data  = out_q[63:56];
  assign strm.m_valid = m_valid_q;
  assign core_in      = core_in_q;
  assign core_mode    = core_mode_q;
  assign core_write   = core_write_q;
  assign busy         = (state_q != FILL);
endmodule

// File: tb/tb_tea_byte_stream.sv
// Bench for tea_byte_stream: a behavioural key-0 TEA core plus a byte-queue output model.
module tb_tea_byte_stream;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] core_in;
  logic [63:0] core_out;
  logic        core_mode;
  logic        core_write;
  logic        core_out_ready;
  logic [63:0] iv;
  logic        iv_load;
  logic        busy;

  tea_byte_stream_if strm ();

  tea_byte_stream #(.ROUNDS(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .strm           (strm),
    .core_in        (core_in),
    .core_mode      (core_mode),
    .core_write     (core_write),
    .core_out       (core_out),
    .core_out_ready (core_out_ready),
    .iv             (iv),
    .iv_load        (iv_load),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] ZERO_CT = 64'h41ea3a0a94baa940;

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] tea_enc(input logic [63:0] b);
    logic [31:0] v0 = b[63:32];
    logic [31:0] v1 = b[31:0];
    logic [31:0] sum = '0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + 32'h9e3779b9;
      v0  = v0 + (((v1 << 4)) ^ (v1 + sum) ^ ((v1 >> 5)));
      v1  = v1 + (((v0 << 4)) ^ (v0 + sum) ^ ((v0 >> 5)));
    end
    return {v0, v1};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] b);
    logic [31:0] v0 = b[63:32];
    logic [31:0] v1 = b[31:0];
    logic [31:0] sum = 32'hc6ef3720;
    for (int i = 0; i < 32; i++) begin
      v1  = v1 - (((v0 << 4)) ^ (v0 + sum) ^ ((v0 >> 5)));
      v0  = v0 - (((v1 << 4)) ^ (v1 + sum) ^ ((v1 >> 5)));
      sum = sum - 32'h9e3779b9;
    end
    return {v0, v1};
  endfunction

  // Core stand-in: result ready 33 edges after the edge that samples core_write.
  int unsigned core_cnt = 0;
  int unsigned writes = 0;
  logic [63:0] last_core_in = '0;
  always @(posedge clk) begin
    if (reset) begin
      core_out_ready <= 1'b0;
      core_out       <= '0;
      core_cnt       <= 0;
    end else if (core_write) begin
      core_out_ready <= 1'b0;
      core_cnt       <= 33;
      core_out       <= core_mode ? tea_dec(core_in) : tea_enc(core_in);
      writes         <= writes + 1;
      last_core_in   <= core_in;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_out_ready <= 1'b1;
    end
  end

  // Output model: each completed input block becomes eight expected bytes.
  logic [7:0] exp_q[$];
`ifdef TEA_STREAM_CBC_EN
  logic [63:0] model_chain = '0;
`endif

  task automatic push_expected(input logic [63:0] blk, input logic mode);
    logic [63:0] r;
`ifdef TEA_STREAM_CBC_EN
    if (!mode) begin
      r = tea_enc(blk ^ model_chain);
      model_chain = r;
    end else begin
      r = tea_dec(blk) ^ model_chain;
      model_chain = blk;
    end
`else
    r = mode ? tea_dec(blk) : tea_enc(blk);
`endif
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(r[63:56]);
      r = r << 8;
    end
  endtask

  int unsigned rx_cnt = 0;
  int unsigned rx_blocks = 0;
  logic [63:0] rx_blk = '0;
  logic [63:0] last_blk = '0;
  bit          stall_q = 1'b0;
  logic [7:0]  stall_data = '0;
  logic [7:0]  exp_b;

  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
      rx_cnt  = 0;
    end else begin
      chk("busy", busy, exp_q.size() != 0);
      chk("s_ready", strm.s_ready, exp_q.size() == 0);
      if (stall_q) begin
        chk("hold_m_valid", strm.m_valid, 1);
        chk("hold_m_data", strm.m_data, stall_data);
      end
      if (exp_q.size() == 0) begin
        chk("m_valid_idle", strm.m_valid, 0);
      end else if (strm.m_valid && strm.m_ready) begin
        exp_b = exp_q.pop_front();
        chk("m_data", strm.m_data, exp_b);
        rx_blk = {rx_blk[55:0], strm.m_data};
        rx_cnt++;
        if (rx_cnt == 8) begin
          last_blk = rx_blk;
          rx_blocks++;
          rx_cnt = 0;
        end
      end
      stall_q    = strm.m_valid && !strm.m_ready;
      stall_data = strm.m_data;
    end
  end

  task automatic load_iv(input logic [63:0] v);
    iv      = v;
    iv_load = 1'b1;
    @(posedge clk);
    #1;
    iv_load = 1'b0;
`ifdef TEA_STREAM_CBC_EN
    model_chain = v;
`endif
  endtask

  // Returns 1ns after the edge that accepted byte 7.
  task automatic send_block(input logic [63:0] blk, input logic mode, input bit toggle, input bit hold_valid);
    logic [63:0] sh = blk;
    bit acc;
    int n;
    for (int i = 0; i < 8; i++) begin
      strm.s_valid = 1'b1;
      strm.s_data  = sh[63:56];
      strm.s_mode  = (i == 0 || !toggle) ? mode : (mode ^ i[0]);
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 300) begin
        @(negedge clk);
        acc = strm.s_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) begin
        chk("s_ready_timeout", 0, 1);
        strm.s_valid = 1'b0;
        return;
      end
      sh = sh << 8;
    end
    push_expected(blk, mode);
    if (!hold_valid) strm.s_valid = 1'b0;
  endtask

  task automatic wait_blocks(input int unsigned target);
    int n = 0;
    while (rx_blocks < target && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("block_timeout", rx_blocks >= target, 1);
  endtask

  int unsigned b0;
  int unsigned w0;
  int n;
  bit seen;
  logic [63:0] c1;
  logic [63:0] c2;

  initial begin
    strm.s_valid = 1'b0;
    strm.s_data  = '0;
    strm.s_mode  = 1'b0;
    strm.m_ready = 1'b1;
    iv           = '0;
    iv_load      = 1'b0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", strm.s_ready, 1);
    chk("rst_m_valid", strm.m_valid, 0);
    chk("rst_m_data", strm.m_data, 0);
    chk("rst_core_write", core_write, 0);
    chk("rst_core_in", core_in, 0);
    chk("rst_core_mode", core_mode, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    chk("model_enc_zero", tea_enc(64'h0), ZERO_CT);
    chk("model_dec_zero", tea_dec(ZERO_CT), 64'h0);

    // Encrypt zero block with s_valid held high; check launch pulse and latency.
    load_iv(64'h0);
    b0 = rx_blocks;
    w0 = writes;
    send_block(64'h0, 1'b0, 1'b0, 1'b1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("core_write_after_E", core_write, 1);
        chk("s_ready_after_b7", strm.s_ready, 0);
        chk("busy_after_E", busy, 1);
      end
      if (n == 2) chk("core_write_one_cycle", core_write, 0);
      seen = strm.m_valid;
    end
    chk("first_byte_latency", n, 36);
    strm.s_valid = 1'b0;
    wait_blocks(b0 + 1);
    chk("ecb_enc_zero", last_blk, ZERO_CT);
    chk("write_count", writes - w0, 1);
    chk("core_in_ecb", last_core_in, 64'h0);

    // Decrypt back.
    load_iv(64'h0);
    b0 = rx_blocks;
    send_block(ZERO_CT, 1'b1, 1'b0, 1'b0);
    wait_blocks(b0 + 1);
    chk("ecb_dec", last_blk, 64'h0);

    // Mode toggling on bytes 1-7 must be ignored.
    load_iv(64'h0);
    b0 = rx_blocks;
    send_block(64'h0, 1'b0, 1'b1, 1'b0);
    wait_blocks(b0 + 1);
    chk("mode_toggle", last_blk, ZERO_CT);

    // Backpressure on the first output byte.
    load_iv(64'h0);
    strm.m_ready = 1'b0;
    b0 = rx_blocks;
    send_block(64'h0, 1'b0, 1'b0, 1'b0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = strm.m_valid;
    end
    chk("bp_first_valid", seen, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_m_data", strm.m_data, 8'h41);
      chk("bp_m_valid", strm.m_valid, 1);
    end
    @(posedge clk);
    #1;
    strm.m_ready = 1'b1;
    wait_blocks(b0 + 1);
    chk("bp_block", last_blk, ZERO_CT);

    // Reset after three bytes have drained.
    load_iv(64'h0);
    send_block(64'h0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (rx_cnt < 3 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain3_reached", rx_cnt, 3);
    reset = 1'b1;
    exp_q.delete();
`ifdef TEA_STREAM_CBC_EN
    model_chain = '0;
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_m_valid", strm.m_valid, 0);
    chk("midrst_s_ready", strm.s_ready, 1);
    @(posedge clk);
    #1;
    b0 = rx_blocks;
    send_block(64'h0, 1'b0, 1'b0, 1'b0);
    wait_blocks(b0 + 1);
    chk("post_reset_enc", last_blk, ZERO_CT);

`ifdef TEA_STREAM_CBC_EN
    load_iv(64'h0);
    b0 = rx_blocks;
    send_block(64'h0, 1'b0, 1'b0, 1'b0);
    wait_blocks(b0 + 1);
    c1 = last_blk;
    chk("cbc_blk1", c1, ZERO_CT);
    send_block(64'h0, 1'b0, 1'b0, 1'b0);
    wait_blocks(b0 + 2);
    c2 = last_blk;
    chk("cbc_blk2", c2, tea_enc(ZERO_CT));
    checks++;
    if (c2 === c1) begin
      failures++;
      $display("FAIL cbc_blk2_distinct actual=%h required=not %h", c2, c1);
    end
    load_iv(64'h0);
    send_block(c1, 1'b1, 1'b0, 1'b0);
    wait_blocks(b0 + 3);
    chk("cbc_dec1", last_blk, 64'h0);
    send_block(c2, 1'b1, 1'b0, 1'b0);
    wait_blocks(b0 + 4);
    chk("cbc_dec2", last_blk, 64'h0);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
